// File: rtl/acog_wback_mt_if.sv
// Retire bundle from decode/execute into the multi-context write-back stage.
//   state_in, ctx_in, opcode_in          : pipeline state, retiring context, instruction
//   execute_in, d_is_zero_in, d_is_one_in: condition and D-operand status
//   save_c_in/save_z_in, flag_c_in/flag_z_in : flag commit strobes and values
//   save_pc_from_s_in, save_pc_from_pc_plus_1_in, call_in, ret_in : PC update requests
//   s_data_in                            : S operand (indirect jump target)
//   ctx_enable_in                        : per-context run mask for the scheduler
// master = driver (decoder side), slave = write-back stage.
interface acog_wback_mt_if #(
   parameter int unsigned NUM_CTX = 4
);
   localparam int unsigned CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

   logic [1:0]         state_in;
   logic [CTX_W-1:0]   ctx_in;
   logic [31:0]        opcode_in;
   logic               execute_in;
   logic               d_is_zero_in;
   logic               d_is_one_in;
   logic               save_c_in;
   logic               save_z_in;
   logic               flag_c_in;
   logic               flag_z_in;
   logic               save_pc_from_s_in;
   logic               save_pc_from_pc_plus_1_in;
   logic               call_in;
   logic               ret_in;
   logic [31:0]        s_data_in;
   logic [NUM_CTX-1:0] ctx_enable_in;

   modport master (
      output state_in, ctx_in, opcode_in, execute_in, d_is_zero_in, d_is_one_in,
             save_c_in, save_z_in, flag_c_in, flag_z_in, save_pc_from_s_in,
             save_pc_from_pc_plus_1_in, call_in, ret_in, s_data_in, ctx_enable_in
   );

   modport slave (
      input  state_in, ctx_in, opcode_in, execute_in, d_is_zero_in, d_is_one_in,
             save_c_in, save_z_in, flag_c_in, flag_z_in, save_pc_from_s_in,
             save_pc_from_pc_plus_1_in, call_in, ret_in, s_data_in, ctx_enable_in
   );
endinterface

// File: rtl/acog_wback_mt.sv
// Multi-context write-back stage. Keeps PC, C/Z and a circular return stack per
// hardware context, commits them in the write-back state and picks the next
// context to fetch by round-robin over the enabled contexts.
//   clk_in, reset_in (sync, active-low)
//   wb            : retire bundle (acog_wback_mt_if.slave)
//   rd_ctx_in     : context shown on the combinational read port
//   pc_o, pc_plus_1_o, flag_c_o, flag_z_o : read port
//   next_ctx_o, idle_o : registered scheduler result
//   stack_ovf_o, stack_unf_o : sticky per-context stack overflow/underflow
module acog_wback_mt #(
   parameter int unsigned     PC_W        = 9,
   parameter int unsigned     NUM_CTX     = 4,
   parameter int unsigned     STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC    = 9'h1F4,
   localparam int unsigned    CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  logic               clk_in,
   input  logic               reset_in,
   acog_wback_mt_if.slave     wb,
   input  logic [CTX_W-1:0]   rd_ctx_in,
   output logic [PC_W-1:0]    pc_o,
   output logic [PC_W-1:0]    pc_plus_1_o,
   output logic               flag_c_o,
   output logic               flag_z_o,
   output logic [CTX_W-1:0]   next_ctx_o,
   output logic               idle_o,
   output logic [NUM_CTX-1:0] stack_ovf_o,
   output logic [NUM_CTX-1:0] stack_unf_o
);
   localparam logic [1:0] ST_WBACK = 2'd3;
   localparam int unsigned OP_I    = 22;
   localparam logic [5:0] I_DJNZ  = 6'b111001;
   localparam logic [5:0] I_TJNZ  = 6'b111010;
   localparam logic [5:0] I_TJZ   = 6'b111011;
   localparam int unsigned PTR_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(STACK_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STACK_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

   logic [PC_W-1:0]    pc_q [NUM_CTX];
   logic [PC_W-1:0]    pc_d [NUM_CTX];
   logic [PC_W-1:0]    stk_q [NUM_CTX][STACK_DEPTH];
   logic [PC_W-1:0]    stk_d [NUM_CTX][STACK_DEPTH];
   logic [PTR_W-1:0]   wptr_q [NUM_CTX];
   logic [PTR_W-1:0]   wptr_d [NUM_CTX];
   logic [CNT_W-1:0]   cnt_q [NUM_CTX];
   logic [CNT_W-1:0]   cnt_d [NUM_CTX];
   logic [NUM_CTX-1:0] c_q, c_d, z_q, z_d, ovf_q, ovf_d, unf_q, unf_d;
   logic [CTX_W-1:0]   next_ctx_q, next_ctx_d;
   logic               idle_q, idle_d;

   logic               wb_valid;
   logic [CTX_W-1:0]   cx;
   logic [PC_W-1:0]    p1, tgt, s_tgt;
   logic [PTR_W-1:0]   wptr_cur, wptr_prev, wptr_next;
   logic [CNT_W-1:0]   cnt_cur;
   logic [5:0]         op;
   logic               do_ret, do_call;
   logic [CTX_W-1:0]   sched_ctx;
   logic               sched_found;
   logic [31:0]        sched_idx;
   logic               rd_ok;

   // Out-of-range contexts are ignored, scheduler included.
   assign wb_valid  = (wb.state_in == ST_WBACK) && (32'(wb.ctx_in) < NUM_CTX);
   assign cx        = wb.ctx_in;
   assign p1        = pc_q[cx] + PC_W'(1);
   assign s_tgt     = wb.s_data_in[PC_W-1:0];
   assign tgt       = wb.opcode_in[OP_I] ? wb.opcode_in[PC_W-1:0] : s_tgt;
   assign op        = wb.opcode_in[31:26];
   assign wptr_cur  = wptr_q[cx];
   assign cnt_cur   = cnt_q[cx];
   // wptr points at the next free slot; the top entry sits one below it.
   assign wptr_prev = (wptr_cur == '0) ? PTR_LAST : wptr_cur - PTR_W'(1);
   assign wptr_next = (wptr_cur == PTR_LAST) ? '0 : wptr_cur + PTR_W'(1);
   assign do_ret    = wb.ret_in & wb.execute_in;
   assign do_call   = wb.call_in & wb.execute_in;

   // Round-robin: search c+1 .. c+NUM_CTX (the last candidate is c itself).
   always_comb begin
      sched_ctx   = wb.ctx_in;
      sched_found = 1'b0;
      sched_idx   = '0;
      for (int unsigned i = 1; i <= NUM_CTX; i++) begin
         sched_idx = (32'(wb.ctx_in) + i) % NUM_CTX;
         if (!sched_found && wb.ctx_enable_in[sched_idx]) begin
            sched_ctx   = CTX_W'(sched_idx);
            sched_found = 1'b1;
         end
      end
   end

   always_comb begin
      pc_d       = pc_q;
      stk_d      = stk_q;
      wptr_d     = wptr_q;
      cnt_d      = cnt_q;
      c_d        = c_q;
      z_d        = z_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      next_ctx_d = next_ctx_q;
      idle_d     = idle_q;
      if (wb_valid) begin
         if (wb.save_c_in) c_d[cx] = wb.flag_c_in;
         if (wb.save_z_in) z_d[cx] = wb.flag_z_in;

         if (do_ret) begin
            if (cnt_cur != '0) begin
               pc_d[cx]   = stk_q[cx][wptr_prev];
               wptr_d[cx] = wptr_prev;
               cnt_d[cx]  = cnt_cur - CNT_W'(1);
            end else begin
               pc_d[cx]  = p1;
               unf_d[cx] = 1'b1;
            end
         end else if (do_call) begin
            // A full stack overwrites its oldest entry.
            stk_d[cx][wptr_cur] = p1;
            wptr_d[cx]          = wptr_next;
            if (cnt_cur == CNT_FULL) ovf_d[cx] = 1'b1;
            else                     cnt_d[cx] = cnt_cur + CNT_W'(1);
            pc_d[cx] = tgt;
         end else if (op == I_DJNZ) begin
            pc_d[cx] = (wb.execute_in && !wb.d_is_one_in) ? s_tgt : p1;
         end else if (op == I_TJNZ) begin
            pc_d[cx] = (wb.execute_in && !wb.d_is_zero_in) ? s_tgt : p1;
         end else if (op == I_TJZ) begin
            pc_d[cx] = (wb.execute_in && wb.d_is_zero_in) ? s_tgt : p1;
         end else if (wb.save_pc_from_pc_plus_1_in) begin
            pc_d[cx] = p1;
         end else if (wb.save_pc_from_s_in) begin
            pc_d[cx] = tgt;
         end

         next_ctx_d = sched_ctx;
         idle_d     = !sched_found;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         for (int i = 0; i < NUM_CTX; i++) begin
            pc_q[i]   <= RESET_PC;
            wptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         c_q        <= '0;
         z_q        <= '0;
         ovf_q      <= '0;
         unf_q      <= '0;
         next_ctx_q <= '0;
         idle_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         wptr_q     <= wptr_d;
         cnt_q      <= cnt_d;
         c_q        <= c_d;
         z_q        <= z_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         next_ctx_q <= next_ctx_d;
         idle_q     <= idle_d;
      end
   end

   // Stack storage needs no reset value; only the count decides validity.
   always_ff @(posedge clk_in) begin
      if (reset_in) stk_q <= stk_d;
   end

   assign rd_ok       = 32'(rd_ctx_in) < NUM_CTX;
   assign pc_o        = rd_ok ? pc_q[rd_ctx_in] : '0;
   assign pc_plus_1_o = pc_o + PC_W'(1);
   assign flag_c_o    = rd_ok ? c_q[rd_ctx_in] : 1'b0;
   assign flag_z_o    = rd_ok ? z_q[rd_ctx_in] : 1'b0;
   assign next_ctx_o  = next_ctx_q;
   assign idle_o      = idle_q;
   assign stack_ovf_o = ovf_q;
   assign stack_unf_o = unf_q;
endmodule

// File: tb/tb_acog_wback_mt.sv
module tb_acog_wback_mt;
   localparam int unsigned NUM_CTX = 4;
   localparam logic [1:0] ST_WBACK = 2'd3;
   localparam logic [5:0] OP_DJNZ  = 6'b111001;
   localparam logic [5:0] OP_TJNZ  = 6'b111010;
   localparam logic [5:0] OP_TJZ   = 6'b111011;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] rd_ctx;
   logic [8:0] pc, pc_p1;
   logic       fc, fz, idle;
   logic [1:0] next_ctx;
   logic [3:0] ovf, unf;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   acog_wback_mt_if #(.NUM_CTX(NUM_CTX)) wb_if ();

   acog_wback_mt #(
      .PC_W(9), .NUM_CTX(NUM_CTX), .STACK_DEPTH(4), .RESET_PC(9'h1F4)
   ) dut (
      .clk_in(clk), .reset_in(reset_n), .wb(wb_if), .rd_ctx_in(rd_ctx),
      .pc_o(pc), .pc_plus_1_o(pc_p1), .flag_c_o(fc), .flag_z_o(fz),
      .next_ctx_o(next_ctx), .idle_o(idle), .stack_ovf_o(ovf), .stack_unf_o(unf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      wb_if.state_in = 2'd0;  wb_if.ctx_in = '0;  wb_if.opcode_in = '0;
      wb_if.execute_in = 0;   wb_if.d_is_zero_in = 0; wb_if.d_is_one_in = 0;
      wb_if.save_c_in = 0;    wb_if.save_z_in = 0;    wb_if.flag_c_in = 0;
      wb_if.flag_z_in = 0;    wb_if.save_pc_from_s_in = 0;
      wb_if.save_pc_from_pc_plus_1_in = 0; wb_if.call_in = 0; wb_if.ret_in = 0;
      wb_if.s_data_in = '0;
   endtask

   task automatic commit();
      wb_if.state_in = ST_WBACK;
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic set_pc(input logic [1:0] c, input logic [8:0] v);
      wb_if.ctx_in = c; wb_if.save_pc_from_s_in = 1; wb_if.s_data_in = {23'd0, v};
      commit();
   endtask

   task automatic call_op(input logic [1:0] c, input logic [8:0] imm);
      wb_if.ctx_in = c; wb_if.call_in = 1; wb_if.execute_in = 1;
      wb_if.opcode_in = 32'h0040_0000 | {23'd0, imm};
      wb_if.s_data_in = 32'h155;
      commit();
   endtask

   task automatic ret_op(input logic [1:0] c);
      wb_if.ctx_in = c; wb_if.ret_in = 1; wb_if.execute_in = 1;
      commit();
   endtask

   task automatic jump_op(input logic [1:0] c, input logic [5:0] op, input logic exe,
                          input logic dz, input logic d1);
      wb_if.ctx_in = c; wb_if.opcode_in = {op, 26'd0}; wb_if.execute_in = exe;
      wb_if.d_is_zero_in = dz; wb_if.d_is_one_in = d1; wb_if.s_data_in = 32'h123;
      commit();
   endtask

   task automatic chk_pc(input string tag, input logic [1:0] c, input logic [8:0] exp);
      rd_ctx = c;
      #1;
      check_eq(tag, {23'd0, pc}, {23'd0, exp});
   endtask

   initial begin
      reset_n = 0;
      clear_in();
      wb_if.ctx_enable_in = 4'hF;
      rd_ctx = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;

      // 1: reset state and PC wrap
      for (int i = 0; i < 4; i++) begin
         rd_ctx = 2'(i);
         #1;
         check_eq($sformatf("rst_pc%0d", i), {23'd0, pc}, 32'h1F4);
         check_eq($sformatf("rst_cz%0d", i), {30'd0, fc, fz}, 32'h0);
      end
      check_eq("rst_next", {30'd0, next_ctx}, 0);
      check_eq("rst_idle", {31'd0, idle}, 0);
      check_eq("rst_ovf_unf", {24'd0, ovf, unf}, 0);
      set_pc(0, 9'h1FF);
      rd_ctx = 0; #1;
      check_eq("pc_plus_1_wrap", {23'd0, pc_p1}, 32'h000);
      wb_if.ctx_in = 0; wb_if.save_pc_from_pc_plus_1_in = 1;
      commit();
      chk_pc("pc_wrap", 0, 9'h000);
      wb_if.ctx_in = 3; wb_if.save_c_in = 1; wb_if.flag_c_in = 1;
      wb_if.save_z_in = 1; wb_if.flag_z_in = 0;
      commit();
      rd_ctx = 3; #1;
      check_eq("flags_c_noexec", {30'd0, fc, fz}, 32'h2);
      wb_if.ctx_in = 3; wb_if.save_z_in = 1; wb_if.flag_z_in = 1;
      commit();
      rd_ctx = 3; #1;
      check_eq("flags_z_only", {30'd0, fc, fz}, 32'h3);
      chk_pc("flags_pc_hold", 3, 9'h1F4);

      // 2: call/ret on ctx 2, ctx 1 untouched
      set_pc(2, 9'h010);
      set_pc(1, 9'h0AA);
      call_op(2, 9'h080);
      chk_pc("call_imm", 2, 9'h080);
      chk_pc("call_other_ctx", 1, 9'h0AA);
      ret_op(2);
      chk_pc("ret_pop", 2, 9'h011);
      chk_pc("ret_other_ctx", 1, 9'h0AA);
      check_eq("ret_no_unf", {28'd0, unf}, 0);

      // 3: overflow / underflow on ctx 0
      for (int k = 1; k <= 5; k++) begin
         set_pc(0, 9'(k * 16));
         call_op(0, 9'h100);
         if (k == 4) check_eq("ovf_at_depth", {28'd0, ovf}, 0);
      end
      chk_pc("call5_pc", 0, 9'h100);
      check_eq("ovf_set", {28'd0, ovf}, 32'h1);
      ret_op(0); chk_pc("pop1", 0, 9'h051);
      ret_op(0); chk_pc("pop2", 0, 9'h041);
      ret_op(0); chk_pc("pop3", 0, 9'h031);
      ret_op(0); chk_pc("pop4", 0, 9'h021);
      check_eq("unf_before_empty", {28'd0, unf}, 0);
      ret_op(0); chk_pc("pop_empty", 0, 9'h022);
      check_eq("unf_set", {28'd0, unf}, 32'h1);

      // 4: conditional jumps on ctx 1
      set_pc(1, 9'h040); jump_op(1, OP_DJNZ, 1, 0, 0); chk_pc("djnz_taken", 1, 9'h123);
      set_pc(1, 9'h040); jump_op(1, OP_DJNZ, 1, 0, 1); chk_pc("djnz_d1", 1, 9'h041);
      set_pc(1, 9'h040); jump_op(1, OP_DJNZ, 0, 0, 0); chk_pc("djnz_noexec", 1, 9'h041);
      set_pc(1, 9'h040); jump_op(1, OP_TJNZ, 1, 0, 0); chk_pc("tjnz_taken", 1, 9'h123);
      set_pc(1, 9'h040); jump_op(1, OP_TJNZ, 1, 1, 0); chk_pc("tjnz_zero", 1, 9'h041);
      set_pc(1, 9'h040); jump_op(1, OP_TJNZ, 0, 0, 0); chk_pc("tjnz_noexec", 1, 9'h041);
      set_pc(1, 9'h040); jump_op(1, OP_TJZ, 1, 1, 0);  chk_pc("tjz_taken", 1, 9'h123);
      set_pc(1, 9'h040); jump_op(1, OP_TJZ, 1, 0, 0);  chk_pc("tjz_nonzero", 1, 9'h041);
      set_pc(1, 9'h040); jump_op(1, OP_TJZ, 0, 1, 0);  chk_pc("tjz_noexec", 1, 9'h041);

      // call+ret together: ret wins, no push
      set_pc(3, 9'h060);
      wb_if.ctx_in = 3; wb_if.call_in = 1; wb_if.ret_in = 1; wb_if.execute_in = 1;
      wb_if.opcode_in = 32'h0040_0080;
      commit();
      chk_pc("callret_ret_wins", 3, 9'h061);
      check_eq("callret_unf", {28'd0, unf}, 32'h9);
      ret_op(3);
      chk_pc("callret_no_push", 3, 9'h062);

      // 5: scheduler
      wb_if.ctx_enable_in = 4'b1010;
      wb_if.ctx_in = 1; commit();
      check_eq("sched_1_to_3", {30'd0, next_ctx}, 3);
      check_eq("sched_not_idle", {31'd0, idle}, 0);
      wb_if.ctx_in = 3; commit();
      check_eq("sched_3_wrap_1", {30'd0, next_ctx}, 1);
      wb_if.ctx_enable_in = 4'b0000;
      wb_if.ctx_in = 2; commit();
      check_eq("sched_none_ctx", {30'd0, next_ctx}, 2);
      check_eq("sched_none_idle", {31'd0, idle}, 1);
      wb_if.ctx_enable_in = 4'b0100;
      wb_if.ctx_in = 2; commit();
      check_eq("sched_self", {30'd0, next_ctx}, 2);
      check_eq("sched_self_idle", {31'd0, idle}, 0);

      // 6: reset overrides WBACK; non-WBACK state is inert
      wb_if.ctx_enable_in = 4'b0000;
      wb_if.ctx_in = 1; commit();
      check_eq("pre_rst_idle", {31'd0, idle}, 1);
      wb_if.ctx_enable_in = 4'hF;
      wb_if.ctx_in = 0; wb_if.call_in = 1; wb_if.execute_in = 1;
      wb_if.opcode_in = 32'h0040_0080; wb_if.state_in = ST_WBACK;
      reset_n = 0;
      @(posedge clk);
      #1;
      reset_n = 1;
      clear_in();
      chk_pc("rst_wback_pc", 0, 9'h1F4);
      check_eq("rst_wback_flags", {24'd0, ovf, unf}, 0);
      check_eq("rst_wback_next", {30'd0, next_ctx}, 0);
      check_eq("rst_wback_idle", {31'd0, idle}, 0);
      ret_op(0);
      chk_pc("rst_no_push", 0, 9'h1F5);
      check_eq("rst_no_push_unf", {28'd0, unf}, 32'h1);
      check_eq("next_after_ret", {30'd0, next_ctx}, 1);
      wb_if.state_in = 2'd1; wb_if.ctx_in = 2; wb_if.save_pc_from_s_in = 1;
      wb_if.s_data_in = 32'h0FF; wb_if.save_c_in = 1; wb_if.flag_c_in = 1;
      wb_if.call_in = 1; wb_if.execute_in = 1;
      @(posedge clk);
      #1;
      clear_in();
      chk_pc("nowb_pc", 2, 9'h1F4);
      check_eq("nowb_c", {31'd0, fc}, 0);
      check_eq("nowb_next", {30'd0, next_ctx}, 1);
      check_eq("nowb_ovf", {28'd0, ovf}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
